stream_minmax_tracker: RTL and testbench



---
 rtl/stream_minmax_tracker_pkg.sv | 21 ++
 rtl/stream_minmax_tracker_mag.sv | 25 ++
 rtl/stream_minmax_tracker.sv | 128 ++++++++++++
 tb/tb_stream_minmax_tracker.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_minmax_tracker_pkg.sv
// Shared types and constants for the streaming min/max tracker.
package stream_minmax_tracker_pkg;

   // Frame FSM: collecting the first beat, accumulating, holding a result.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_IDX_W = 8;
   localparam int MAX_BEATS = 2 ** DEF_IDX_W;

   // Longest frame for a given index width; a frame reaching this many
   // beats without in_last is closed and flagged truncated.
   function automatic int max_beats(input int idx_w);
      return 2 ** idx_w;
   endfunction

endpackage

// File: rtl/stream_minmax_tracker_mag.sv
// Combinational magnitude comparator, unsigned or two's-complement signed.
module mag_cmp #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   logic [WIDTH-1:0] a_key;
   logic [WIDTH-1:0] b_key;

   // Flipping the sign bit maps two's-complement order onto unsigned order,
   // so one unsigned comparator serves both modes.
   assign a_key = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
   assign b_key = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};

   assign gt = (a_key > b_key);
   assign lt = (a_key < b_key);
   assign eq = (a_key == b_key);

endmodule

// File: rtl/stream_minmax_tracker.sv
// Streaming frame tracker: reports max/min values, their first beat index,
// beat count and termination cause of each frame over valid/ready.
module stream_minmax_tracker
   import stream_minmax_tracker_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             signed_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic [IDX_W-1:0] out_max_idx,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [IDX_W:0]   out_count,
   output logic             out_signed,
   output logic             out_trunc
);

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(max_beats(IDX_W));

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [IDX_W-1:0] beat_idx;
   logic [IDX_W:0]   cnt_nxt;
   logic             at_limit;
   logic             closing;
   logic [2:0]       rel_max;   // {gt, eq, lt} of in_data vs running max
   logic [2:0]       rel_min;   // {gt, eq, lt} of in_data vs running min
   logic             upd_max;
   logic             upd_min;

   assign in_ready  = (state != ST_HOLD);
   assign out_valid = (state == ST_HOLD);

   // A beat presented together with flush is dropped.
   assign accept   = in_valid && in_ready && !flush;
   assign beat_idx = (state == ST_IDLE) ? '0 : out_count[IDX_W-1:0];
   assign cnt_nxt  = {1'b0, beat_idx} + (IDX_W + 1)'(1);
   assign at_limit = (cnt_nxt == FULL_CNT);
   assign closing  = accept && (in_last || at_limit);

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
      .a        (in_data),
      .b        (out_max),
      .is_signed(out_signed),
      .gt       (rel_max[2]),
      .eq       (rel_max[1]),
      .lt       (rel_max[0])
   );

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
      .a        (in_data),
      .b        (out_min),
      .is_signed(out_signed),
      .gt       (rel_min[2]),
      .eq       (rel_min[1]),
      .lt       (rel_min[0])
   );

   // Strict compares only: a tie keeps the earlier index.
   assign upd_max = (rel_max == 3'b100);
   assign upd_min = (rel_min == 3'b001);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (accept)    state_nxt = closing ? ST_HOLD : ST_ACCUM;
            ST_ACCUM: if (closing)   state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
         endcase
      end
   end

   // Running result registers double as the held output; they only move on
   // an accepted beat, so they stay stable throughout HOLD and after flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_max     <= '0;
         out_min     <= '0;
         out_max_idx <= '0;
         out_min_idx <= '0;
         out_count   <= '0;
         out_signed  <= 1'b0;
         out_trunc   <= 1'b0;
      end else if (accept) begin
         out_count <= cnt_nxt;
         out_trunc <= at_limit && !in_last;
         if (state == ST_IDLE) begin
            out_max     <= in_data;
            out_min     <= in_data;
            out_max_idx <= '0;
            out_min_idx <= '0;
            out_signed  <= signed_mode;
         end else begin
            if (upd_max) begin
               out_max     <= in_data;
               out_max_idx <= beat_idx;
            end
            if (upd_min) begin
               out_min     <= in_data;
               out_min_idx <= beat_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Self-checking bench: directed test-plan frames plus randomized frames
// scored against a queue-based reference model. Two trackers share the bus:
// the default one (IDX_W=8) and a short one (IDX_W=2) for length limits.
module tb_stream_minmax_tracker;

   typedef struct packed {
      logic [31:0] mx;
      logic [31:0] mn;
      logic [7:0]  mx_i;
      logic [7:0]  mn_i;
      logic [8:0]  cnt;
      logic        sg;
      logic        tr;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, signed_mode, in_valid, in_last, out_ready;
   logic [31:0] in_data;
   bit          sel;

   logic        rdy0, ov0, sg0, tr0;
   logic [31:0] mx0, mn0;
   logic [7:0]  mxi0, mni0;
   logic [8:0]  cnt0;
   logic        rdy1, ov1, sg1, tr1;
   logic [31:0] mx1, mn1;
   logic [1:0]  mxi1, mni1;
   logic [2:0]  cnt1;

   logic        rdy, ov;
   res_t        obs;
   res_t        exp_r;
   logic [31:0] q[$];
   bit          q_mode;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   stream_minmax_tracker dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .signed_mode(signed_mode),
      .in_valid(in_valid & ~sel), .in_ready(rdy0), .in_data(in_data),
      .in_last(in_last), .out_valid(ov0), .out_ready(out_ready & ~sel),
      .out_max(mx0), .out_min(mn0), .out_max_idx(mxi0), .out_min_idx(mni0),
      .out_count(cnt0), .out_signed(sg0), .out_trunc(tr0)
   );

   stream_minmax_tracker #(.WIDTH(32), .IDX_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .signed_mode(signed_mode),
      .in_valid(in_valid & sel), .in_ready(rdy1), .in_data(in_data),
      .in_last(in_last), .out_valid(ov1), .out_ready(out_ready & sel),
      .out_max(mx1), .out_min(mn1), .out_max_idx(mxi1), .out_min_idx(mni1),
      .out_count(cnt1), .out_signed(sg1), .out_trunc(tr1)
   );

   // Present the selected tracker's outputs in a common shape.
   always_comb begin
      if (sel) begin
         rdy = rdy1; ov = ov1;
         obs.mx = mx1; obs.mn = mn1;
         obs.mx_i = {6'd0, mxi1}; obs.mn_i = {6'd0, mni1};
         obs.cnt = {6'd0, cnt1}; obs.sg = sg1; obs.tr = tr1;
      end else begin
         rdy = rdy0; ov = ov0;
         obs.mx = mx0; obs.mn = mn0;
         obs.mx_i = mxi0; obs.mn_i = mni0;
         obs.cnt = cnt0; obs.sg = sg0; obs.tr = tr0;
      end
   end

   function automatic res_t mk(input logic [31:0] mx, input logic [31:0] mn,
                               input int mxi, input int mni, input int cnt,
                               input bit sg, input bit tr);
      res_t r;
      r.mx = mx; r.mn = mn; r.mx_i = 8'(mxi); r.mn_i = 8'(mni);
      r.cnt = 9'(cnt); r.sg = sg; r.tr = tr;
      return r;
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("max=%h min=%h max_idx=%0d min_idx=%0d count=%0d signed=%0b trunc=%0b",
                       r.mx, r.mn, r.mx_i, r.mn_i, r.cnt, r.sg, r.tr);
   endfunction

   function automatic bit vgt(input logic [31:0] a, input logic [31:0] b, input bit s);
      return s ? ($signed(a) > $signed(b)) : (a > b);
   endfunction

   // Reference: scan a whole frame, first strict extreme wins.
   function automatic res_t model(input logic [31:0] fq[$], input bit s, input bit tr);
      res_t r;
      r = '0;
      r.mx = fq[0]; r.mn = fq[0];
      for (int i = 1; i < fq.size(); i++) begin
         if (vgt(fq[i], r.mx, s)) begin r.mx = fq[i]; r.mx_i = 8'(i); end
         if (vgt(r.mn, fq[i], s)) begin r.mn = fq[i]; r.mn_i = 8'(i); end
      end
      r.cnt = 9'(fq.size()); r.sg = s; r.tr = tr;
      return r;
   endfunction

   function automatic int lim();
      return sel ? 4 : 256;
   endfunction

   // Drive one beat for a single cycle (tracker must be ready) and update
   // the model; on frame close exp_r holds the expected result.
   task automatic send_beat(input logic [31:0] d, input bit last, input bit sm,
                            output bit closed);
      in_valid = 1'b1; in_data = d; in_last = last; signed_mode = sm;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      q.push_back(d);
      if (q.size() == 1) q_mode = sm;
      closed = last || (q.size() == lim());
      if (closed) begin
         exp_r = model(q, q_mode, !last);
         q.delete();
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 0; signed_mode = 0; in_valid = 0; in_last = 0;
      out_ready = 0; in_data = '0; sel = 0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         #1;
         n_chk++;
         if (obs !== mk(0, 0, 0, 0, 0, 0, 0) || ov !== 1'b0)
            $display("FAIL reset_values dut%0d: got %s valid=%b, want all zero", s, fmt(obs), ov);
         else n_pass++;
      end
      sel = 0;
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (rdy !== 1'b1 || ov !== 1'b0)
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", rdy, ov);
      else n_pass++;
   endtask

   task automatic test_unsigned_basic();
      logic [31:0] d[5] = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1};
      bit c;
      for (int i = 0; i < 5; i++) begin
         send_beat(d[i], i == 4, 1'b0, c);
         if (!c) begin
            n_chk++;
            if (ov !== 1'b0) $display("FAIL unsigned_midframe_valid beat %0d: got %b, want 0", i, ov);
            else n_pass++;
         end
      end
      n_chk++;
      if (ov !== 1'b1) $display("FAIL unsigned_latency: got out_valid=%b, want 1", ov);
      else n_pass++;
      n_chk++;
      if (obs !== mk(9, 1, 1, 4, 5, 0, 0))
         $display("FAIL unsigned_result: got %s, want %s", fmt(obs), fmt(mk(9, 1, 1, 4, 5, 0, 0)));
      else n_pass++;
      release_result();
      n_chk++;
      if (ov !== 1'b0 || rdy !== 1'b1) $display("FAIL unsigned_release: got valid=%b ready=%b, want 0/1", ov, rdy);
      else n_pass++;
   endtask

   task automatic test_signed();
      logic [31:0] d[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      bit c;
      res_t e;
      for (int m = 1; m >= 0; m--) begin
         // mode toggles after the first beat must not matter
         for (int i = 0; i < 4; i++) send_beat(d[i], i == 3, (i == 0) ? bit'(m) : !bit'(m), c);
         e = m ? mk(32'h7FFF_FFFF, 32'h8000_0000, 2, 3, 4, 1, 0)
               : mk(32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 4, 0, 0);
         n_chk++;
         if (ov !== 1'b1 || obs !== e)
            $display("FAIL signed_frame mode=%0d: got valid=%b %s, want %s", m, ov, fmt(obs), fmt(e));
         else n_pass++;
         release_result();
      end
   endtask

   task automatic test_backpressure();
      bit c;
      res_t e;
      send_beat(32'd3, 1'b0, 1'b0, c);
      send_beat(32'd6, 1'b1, 1'b0, c);
      e = mk(6, 3, 1, 0, 2, 0, 0);
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
         @(negedge clk);
         n_chk++;
         if (ov !== 1'b1 || rdy !== 1'b0 || obs !== e)
            $display("FAIL backpressure_hold cycle %0d: got valid=%b ready=%b %s, want 1/0 %s",
                     k, ov, rdy, fmt(obs), fmt(e));
         else n_pass++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_result();
      n_chk++;
      if (ov !== 1'b0 || rdy !== 1'b1) $display("FAIL backpressure_release: got valid=%b ready=%b, want 0/1", ov, rdy);
      else n_pass++;
   endtask

   task automatic test_single();
      bit c;
      send_beat(32'd42, 1'b1, 1'b0, c);
      n_chk++;
      if (!c || ov !== 1'b1 || obs !== mk(42, 42, 0, 0, 1, 0, 0))
         $display("FAIL single_beat: got valid=%b %s, want %s", ov, fmt(obs), fmt(mk(42, 42, 0, 0, 1, 0, 0)));
      else n_pass++;
      release_result();
   endtask

   task automatic test_trunc();
      logic [31:0] d[5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
      bit c;
      sel = 1;
      for (int i = 0; i < 4; i++) send_beat(d[i], 1'b0, 1'b0, c);
      n_chk++;
      if (ov !== 1'b1 || obs !== mk(4, 1, 3, 0, 4, 0, 1))
         $display("FAIL trunc_first: got valid=%b %s, want %s", ov, fmt(obs), fmt(mk(4, 1, 3, 0, 4, 0, 1)));
      else n_pass++;
      release_result();
      send_beat(d[4], 1'b1, 1'b0, c);
      n_chk++;
      if (ov !== 1'b1 || obs !== mk(0, 0, 0, 0, 1, 0, 0))
         $display("FAIL trunc_second: got valid=%b %s, want %s", ov, fmt(obs), fmt(mk(0, 0, 0, 0, 1, 0, 0)));
      else n_pass++;
      release_result();
      sel = 0;
   endtask

   task automatic test_flush();
      bit c;
      send_beat(32'd10, 1'b0, 1'b0, c);
      // second beat of a 4-beat frame arrives with flush
      in_valid = 1'b1; in_data = 32'd20; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);
      n_chk++;
      if (ov !== 1'b0 || rdy !== 1'b1) $display("FAIL flush_midframe: got valid=%b ready=%b, want 0/1", ov, rdy);
      else n_pass++;
      send_beat(32'd7, 1'b1, 1'b0, c);
      n_chk++;
      if (ov !== 1'b1 || obs !== mk(7, 7, 0, 0, 1, 0, 0))
         $display("FAIL flush_next_frame: got valid=%b %s, want %s", ov, fmt(obs), fmt(mk(7, 7, 0, 0, 1, 0, 0)));
      else n_pass++;
      // flush a pending result: valid drops, data registers keep values
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_chk++;
      if (ov !== 1'b0 || rdy !== 1'b1 || obs.mx !== 32'd7)
         $display("FAIL flush_hold: got valid=%b ready=%b max=%h, want 0/1/7", ov, rdy, obs.mx);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit c;
      send_beat(32'd3, 1'b0, 1'b0, c);
      send_beat(32'd8, 1'b1, 1'b0, c);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (ov !== 1'b0 || obs !== mk(0, 0, 0, 0, 0, 0, 0))
         $display("FAIL reset_mid_hold: got valid=%b %s, want all zero", ov, fmt(obs));
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_beat(32'd11, 1'b0, 1'b0, c);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      @(negedge clk);
      n_chk++;
      if (ov !== 1'b0 || rdy !== 1'b1) $display("FAIL reset_mid_frame: got valid=%b ready=%b, want 0/1", ov, rdy);
      else n_pass++;
      send_beat(32'd7, 1'b1, 1'b0, c);
      n_chk++;
      if (ov !== 1'b1 || obs !== mk(7, 7, 0, 0, 1, 0, 0))
         $display("FAIL reset_next_frame: got valid=%b %s, want %s", ov, fmt(obs), fmt(mk(7, 7, 0, 0, 1, 0, 0)));
      else n_pass++;
      release_result();
   endtask

   task automatic test_random();
      bit c;
      int len;
      logic [31:0] d;
      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, s ? 7 : 12);
            for (int i = 0; i < len; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  signed_mode = 1'($urandom);
                  @(negedge clk);
               end
               d = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 6)) - 32'd3;
               send_beat(d, i == len - 1, 1'($urandom), c);
               if (c) begin
                  n_chk++;
                  if (ov !== 1'b1 || obs !== exp_r)
                     $display("FAIL random dut%0d frame %0d: got valid=%b %s, want %s",
                              s, f, ov, fmt(obs), fmt(exp_r));
                  else n_pass++;
                  repeat ($urandom_range(0, 3)) @(negedge clk);
                  release_result();
                  n_chk++;
                  if (ov !== 1'b0) $display("FAIL random_release dut%0d frame %0d: got valid=%b, want 0", s, f, ov);
                  else n_pass++;
               end
            end
         end
      end
      sel = 0;
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_backpressure();
      test_single();
      test_trunc();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
